// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/fetch side.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic        loadPC;
  logic [3:0]  ALUCtrl;
  logic        MemRead;
  logic        MemWrite;
  logic        illegal;
  logic [2:0]  state;

  modport master (
    output instr, zero,
    input  PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, ALUCtrl,
           MemRead, MemWrite, illegal, state
  );

  modport slave (
    input  instr, zero,
    output PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, ALUCtrl,
           MemRead, MemWrite, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Five-state multicycle controller for a small RV32I subset (R/I/LW/SW/BEQ).
// Strobes are qualified by the registered state, so async reset clears them at once.
module multicycle_ctrl #(
  parameter logic [3:0] ALU_AND = 4'b0000,
  parameter logic [3:0] ALU_OR  = 4'b0001,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_XOR = 4'b0101,
  parameter logic [3:0] ALU_SUB = 4'b0110,
  parameter logic [3:0] ALU_SLT = 4'b0111,
  parameter logic [3:0] ALU_SRL = 4'b1000,
  parameter logic [3:0] ALU_SLL = 4'b1001,
  parameter logic [3:0] ALU_SRA = 4'b1010
) (
  input  logic          clk,
  input  logic          rst,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       f7_base, f7_alt;
  logic       is_r, is_i, is_lw, is_sw, is_beq, legal;
  logic [3:0] alu;

  assign opcode  = bus.instr[6:0];
  assign f3      = bus.instr[14:12];
  assign f7      = bus.instr[31:25];
  assign f7_base = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);

  always_comb begin
    is_r   = 1'b0;
    is_i   = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    is_beq = 1'b0;
    alu    = ALU_ADD;
    unique case (opcode)
      7'b0110011: begin
        unique case (f3)
          3'b000: begin alu = f7_alt ? ALU_SUB : ALU_ADD; is_r = f7_base | f7_alt; end
          3'b001: begin alu = ALU_SLL; is_r = f7_base; end
          3'b010: begin alu = ALU_SLT; is_r = f7_base; end
          3'b100: begin alu = ALU_XOR; is_r = f7_base; end
          3'b101: begin alu = f7_alt ? ALU_SRA : ALU_SRL; is_r = f7_base | f7_alt; end
          3'b110: begin alu = ALU_OR;  is_r = f7_base; end
          3'b111: begin alu = ALU_AND; is_r = f7_base; end
          default: is_r = 1'b0;
        endcase
      end
      7'b0010011: begin
        unique case (f3)
          3'b000: begin alu = ALU_ADD; is_i = 1'b1; end
          3'b001: begin alu = ALU_SLL; is_i = f7_base; end
          3'b010: begin alu = ALU_SLT; is_i = 1'b1; end
          3'b100: begin alu = ALU_XOR; is_i = 1'b1; end
          3'b101: begin alu = f7_alt ? ALU_SRA : ALU_SRL; is_i = f7_base | f7_alt; end
          3'b110: begin alu = ALU_OR;  is_i = 1'b1; end
          3'b111: begin alu = ALU_AND; is_i = 1'b1; end
          default: is_i = 1'b0;
        endcase
      end
      7'b0000011: begin alu = ALU_ADD; is_lw  = (f3 == 3'b010); end
      7'b0100011: begin alu = ALU_ADD; is_sw  = (f3 == 3'b010); end
      7'b1100011: begin alu = ALU_SUB; is_beq = (f3 == 3'b000); end
      default: alu = ALU_ADD;
    endcase
    // Rejected encodings must not leak a partial decode onto the ALU select.
    if (!(is_r | is_i | is_lw | is_sw | is_beq)) alu = ALU_ADD;
  end

  assign legal = is_r | is_i | is_lw | is_sw | is_beq;

  always_comb begin
    unique case (state_q)
      S_IF:    state_d = S_ID;
      S_ID:    state_d = S_EX;
      S_EX:    state_d = S_MEM;
      S_MEM:   state_d = S_WB;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IF;
    else      state_q <= state_d;
  end

  assign bus.state    = state_q;
  assign bus.ALUCtrl  = alu;
  assign bus.ALUSrc   = is_i | is_lw | is_sw;
  assign bus.MemToReg = is_lw;
  assign bus.MemRead  = (state_q == S_MEM) & is_lw;
  assign bus.MemWrite = (state_q == S_MEM) & is_sw;
  assign bus.RegWrite = (state_q == S_WB) & (is_r | is_i | is_lw);
  assign bus.loadPC   = (state_q == S_WB);
  assign bus.PCSrc    = (state_q == S_WB) & is_beq & bus.zero;
  assign bus.illegal  = (state_q == S_WB) & ~legal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: walks each instruction class through all five states and checks every control.
module tb_multicycle_ctrl;
  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expects to be entered at a negedge with the FSM in IF; leaves it in IF again.
  task automatic run(input string nm, input logic [31:0] ins, input logic z,
                     input logic [3:0] alu, input logic asrc, input logic m2r,
                     input logic rw, input logic mr, input logic mw,
                     input logic pcs, input logic ill);
    bus.instr = ins;
    bus.zero  = z;
    #1;
    for (int st = 0; st < 5; st++) begin
      chk({nm, "_state"},    32'(bus.state),    32'(st));
      chk({nm, "_alu"},      32'(bus.ALUCtrl),  32'(alu));
      chk({nm, "_alusrc"},   32'(bus.ALUSrc),   32'(asrc));
      chk({nm, "_memtoreg"}, 32'(bus.MemToReg), 32'(m2r));
      chk({nm, "_regwrite"}, 32'(bus.RegWrite), 32'(rw  && st == 4));
      chk({nm, "_memread"},  32'(bus.MemRead),  32'(mr  && st == 3));
      chk({nm, "_memwrite"}, 32'(bus.MemWrite), 32'(mw  && st == 3));
      chk({nm, "_loadpc"},   32'(bus.loadPC),   32'(st == 4));
      chk({nm, "_pcsrc"},    32'(bus.PCSrc),    32'(pcs && st == 4));
      chk({nm, "_illegal"},  32'(bus.illegal),  32'(ill && st == 4));
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b0;
    bus.instr = 32'h002081B3;
    bus.zero  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state",    32'(bus.state),    32'd0);
    chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_loadpc",   32'(bus.loadPC),   32'd0);
    rst = 1'b1;

    //        name     instr         z     alu      asrc  m2r   rw    mr    mw    pcs   ill
    run("add",  32'h002081B3, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run("lw",   32'h0000A183, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run("sw",   32'h0030A023, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run("beqz", 32'h00208463, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run("beqn", 32'h00208463, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("ones", 32'hFFFFFFFF, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run("sub",  32'h40208233, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run("srai", 32'h4020D213, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run("badr", 32'h40209233, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run("badlw",32'h0000B183, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Async reset in the middle of an SW's MEM cycle.
    bus.instr = 32'h0030A023;
    bus.zero  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("arst_pre_state", 32'(bus.state),    32'd3);
    chk("arst_pre_mw",    32'(bus.MemWrite), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_mw",    32'(bus.MemWrite), 32'd0);
    chk("arst_state", 32'(bus.state),    32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold", 32'(bus.state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("arst_rel_state", 32'(bus.state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout obs=%0d exp=done", checks);
    $fatal(1, "timeout");
  end
endmodule
